load_store_unit: RTL
====================

# load_store_unit

Multi-cycle data-memory access stage sitting directly downstream of the ALU: it takes the effective address computed by the ALU for LOAD/STORE opcodes, drives a word-addressed data-memory port with a ready handshake, and returns sign/zero-extended load data to the writeback path. It performs byte-lane steering, write-mask generation, alignment checking and an optional bus timeout, presenting a simple start/done interface to the core controller.

## Interface
- TIMEOUT_CYCLES, 16: max cycles `mem_req` may stay high without `mem_ready` (used only with `LSU_TIMEOUT_EN`); must be ≥1.
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  in  1  request pulse; accepted only in IDLE.
- is_store  in  1  1 = store, 0 = load.
- funct3  in  3  access size/sign: 0 B, 1 H, 2 W, 4 BU, 5 HU (stores: 0/1/2 only).
- addr  in  32  effective byte address (ALU output).
- store_data  in  32  rs2 value.
- mem_req  out  1  memory request, held until `mem_ready`.
- mem_we  out  1  write enable, valid with `mem_req`.
- mem_addr  out  32  word address, `{addr[31:2], 2'b00}`.
- mem_wmask  out  4  byte write mask.
- mem_wdata  out  32  lane-steered store data.
- mem_ready  in  1  memory completion; `mem_rdata` valid in the same cycle for loads.
- mem_rdata  in  32  read word.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with `done`: misaligned access, illegal funct3, or timeout.
- load_data  out  32  extended load result; held until the next accepted start.

## Operation
- States: IDLE, ACCESS, DONE, FAULT.
- IDLE: on `start`, register is_store/funct3/addr/store_data. If misaligned (H/HU with addr[0]≠0; W with addr[1:0]≠0) or illegal funct3 (3, 6, 7; or store funct3 > 2) → FAULT. Otherwise → ACCESS.
- ACCESS: `mem_req`=1, with mem_we/mem_addr/mem_wmask/mem_wdata stable from registered values. On `mem_ready`: capture the extended load result (loads only) → DONE.
- DONE: `done`=1, `err`=0 → IDLE.
- FAULT: `done`=1, `err`=1, no memory request ever issued → IDLE. `load_data` is unchanged.
- Lane steering: byte = `mem_rdata[8*addr[1:0] +: 8]`; half = `mem_rdata[16*addr[1] +: 16]`. B/H are sign-extended; BU/HU are zero-extended.
- Store: SB mask = `4'b0001 << addr[1:0]`, wdata = byte placed in its lane, all other lanes 0. SH mask = `4'b0011 << {addr[1],1'b0}`. SW mask = `4'b1111`.
- `start` outside IDLE is ignored (no queueing).
- Reset values: `mem_req`, `mem_we`, `done`, `err`, `busy` = 0; `mem_addr`, `mem_wmask`, `mem_wdata`, `load_data` = 0; state = IDLE.

## Timing
- `start` sampled at edge k; ACCESS occupies cycle k+1 onward.
- With `mem_ready` in the first ACCESS cycle, `done` is high in cycle k+2 (2-cycle minimum latency).
- Each wait cycle adds one cycle of latency.
- A fault asserts `done`/`err` in cycle k+1.
- `load_data` updates on the same edge that enters DONE, so it is valid while `done`=1.
- `mem_ready` outside ACCESS is ignored.
- Reset asserted mid-ACCESS: `mem_req` is 0 in the cycle after the reset edge, and no `done` is generated for the aborted access.
- `done` and the next accepted `start` can never share a cycle, since DONE→IDLE takes one edge.

## Configuration
- `LSU_TIMEOUT_EN` defined: a counter, cleared on entry to ACCESS, increments each ACCESS cycle without `mem_ready`. When it reaches TIMEOUT_CYCLES, the block drops `mem_req` and goes to FAULT (`done`+`err`).
- `mem_ready` in the same cycle the count is reached wins: normal DONE.
- Not defined: no counter; ACCESS waits indefinitely.

## Structure
- Shared package `instruction_types`: funct3 access encodings (LS_B, LS_H, LS_W, LS_BU, LS_HU) and `lsu_state_t` enum.
- Sub-module `lsu_lane_align`: purely combinational; produces mask/wdata from (funct3, addr[1:0], store_data) and the extended load value from (funct3, addr[1:0], mem_rdata).
- The FSM, registers and timeout counter stay in `load_store_unit`.

## Test plan
- Load: mem word 0x80FF7F01 at 0x1000; LB @0x1002 → load_data 0xFFFFFFFF; LBU @0x1002 → 0x000000FF; LH @0x1002 → 0xFFFF80FF; LW @0x1000 → 0x80FF7F01. Each done with err=0 two cycles after start when mem_ready is immediate.
- Store: SB @0x1003 with store_data 0x123456AB → mem_wmask 4'b1000, mem_wdata 0xAB000000, mem_addr 0x1000. SH @0x1002 with 0x0000BEEF → mask 4'b1100, wdata 0xBEEF0000.
- Misaligned: LW @0x1001 or SH @0x1003 → done+err in cycle k+1; mem_req never asserted; load_data unchanged.
- Wait states: mem_ready delayed 3 cycles → mem_req held with stable addr/mask for 4 cycles; done in cycle k+5; a start pulsed during busy is ignored.
- Timeout (`LSU_TIMEOUT_EN`, TIMEOUT_CYCLES=16): mem_ready stuck low → mem_req drops after 16 cycles, then done+err. Without the macro, still busy after 100 cycles.
- Reset: rst_n low for one edge mid-ACCESS → next cycle all outputs 0, state IDLE, no done. A new LW after reset completes normally.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared load/store encodings and LSU state type.
// Imported by load_store_unit and lsu_lane_align.
package instruction_types;

  localparam logic [2:0] LS_B  = 3'd0;
  localparam logic [2:0] LS_H  = 3'd1;
  localparam logic [2:0] LS_W  = 3'd2;
  localparam logic [2:0] LS_BU = 3'd4;
  localparam logic [2:0] LS_HU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE,
    ST_FAULT
  } lsu_state_t;

  typedef struct packed {
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
  } lsu_req_t;

  // Illegal size/sign code or misaligned address for that size
  function automatic logic lsu_fault(
    input logic       st,
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic bad;
    bad = 1'b0;
    unique case (1'b1)
      (f3 == LS_B):  bad = 1'b0;
      (f3 == LS_BU): bad = st;
      (f3 == LS_H):  bad = off[0];
      (f3 == LS_HU): bad = off[0] | st;
      (f3 == LS_W):  bad = |off;
      default:       bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-addressed data-memory port with ready handshake.
// master = LSU side, slave = memory side.
interface load_store_unit_if;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wmask,
    output mem_wdata,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wmask,
    input  mem_wdata,
    output mem_ready,
    output mem_rdata
  );

endinterface

// File: rtl/load_store_unit_lane_align.sv
// lsu_lane_align: byte-lane steering for stores and
// sign/zero extension for loads. Purely combinational.
module lsu_lane_align
  import instruction_types::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  wmask,
  output logic [31:0] wdata,
  output logic [31:0] load_value
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign rd_byte = mem_rdata[{byte_off, 3'b000} +: 8];
  assign rd_half = mem_rdata[{byte_off[1], 4'b0000} +: 16];

  // Place store bytes in their lanes, clear the rest
  always_comb begin
    wmask = '0;
    wdata = '0;
    unique case (1'b1)
      (funct3 == LS_B): begin
        wmask = 4'b0001 << byte_off;
        wdata = {24'b0, store_data[7:0]}
                << {byte_off, 3'b000};
      end
      (funct3 == LS_H): begin
        wmask = 4'b0011 << {byte_off[1], 1'b0};
        wdata = byte_off[1]
              ? {store_data[15:0], 16'b0}
              : {16'b0, store_data[15:0]};
      end
      (funct3 == LS_W): begin
        wmask = 4'b1111;
        wdata = store_data;
      end
      default: ;
    endcase
  end

  // Extract the addressed lane and extend it
  always_comb begin
    load_value = '0;
    unique case (1'b1)
      (funct3 == LS_B):
        load_value = {{24{rd_byte[7]}}, rd_byte};
      (funct3 == LS_BU):
        load_value = {24'b0, rd_byte};
      (funct3 == LS_H):
        load_value = {{16{rd_half[15]}}, rd_half};
      (funct3 == LS_HU):
        load_value = {16'b0, rd_half};
      (funct3 == LS_W):
        load_value = mem_rdata;
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle data-memory access stage.
// Optional bus timeout enabled by defining LSU_TIMEOUT_EN.
module load_store_unit
  import instruction_types::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  load_store_unit_if.master mem,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] load_data
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  lsu_state_t  state;
  lsu_state_t  state_n;
  lsu_req_t    req_q;
  logic        tmo_hit;
  logic        in_access;
  logic        accept;
  logic [3:0]  lane_wmask;
  logic [31:0] lane_wdata;
  logic [31:0] lane_load;

  assign in_access = (state == ST_ACCESS);
  assign accept    = (state == ST_IDLE) & start;

  lsu_lane_align u_align (
    .funct3     (req_q.funct3),
    .byte_off   (req_q.addr[1:0]),
    .store_data (req_q.store_data),
    .mem_rdata  (mem.mem_rdata),
    .wmask      (lane_wmask),
    .wdata      (lane_wdata),
    .load_value (lane_load)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] tmo_q;

  assign tmo_hit = (tmo_q == CW'(TIMEOUT_CYCLES - 1));

  // Count ACCESS cycles spent waiting for mem_ready
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else if (!in_access) begin
      tmo_q <= '0;
    end else if (!mem.mem_ready) begin
      tmo_q <= tmo_q + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state; ready beats a coincident timeout
  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_n = lsu_fault(is_store, funct3,
                              addr[1:0])
                  ? ST_FAULT : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (mem.mem_ready) begin
          state_n = ST_DONE;
        end else if (tmo_hit) begin
          state_n = ST_FAULT;
        end
      end
      ST_DONE:  state_n = ST_IDLE;
      ST_FAULT: state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // Latch the request and the completed load result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q     <= '0;
      load_data <= '0;
    end else begin
      if (accept) begin
        req_q <= '{is_store:   is_store,
                   funct3:     funct3,
                   addr:       addr,
                   store_data: store_data};
      end
      if (in_access && mem.mem_ready
          && !req_q.is_store) begin
        load_data <= lane_load;
      end
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE)
              | (state == ST_FAULT);
  assign err  = (state == ST_FAULT);

  assign mem.mem_req   = in_access;
  assign mem.mem_we    = in_access & req_q.is_store;
  assign mem.mem_addr  = {req_q.addr[31:2], 2'b00};
  assign mem.mem_wmask = mem.mem_we ? lane_wmask : '0;
  assign mem.mem_wdata = mem.mem_we ? lane_wdata : '0;

endmodule
